// File: rtl/float_result_checker.sv
// rtl/float_result_checker.sv - expected-result scoreboard for float IP simulation benches
//
// Purpose:
//   Queues {ID, expected} pairs as the vector loader issues them. Pops one
//   entry per DUT result and compares the two. The compare treats NaNs as
//   equal, treats +0/-0 as equal and accepts an optional ULP tolerance.
//   Keeps saturating pass and error counts. Signals done once the loader
//   reports end-of-file and every queued vector has been checked or the
//   drain timeout has expired.
//
// Ports:
//   i_Clk, i_ARst         clock, asynchronous active-high reset
//   i_ClkEn, i_EoF        loader issue strobe and end-of-file flag
//   iv_FltID, iv_FltExp   vector ID and expected result from the loader
//   i_ResValid, iv_FltRes DUT result strobe and value
//   o_Mismatch            1-cycle pulse on a failed compare
//   ov_ErrID              ID of the most recent mismatch (all-ones on underflow)
//   ov_PassCnt, ov_ErrCnt saturating pass / fail counters
//   o_Overflow            sticky: push dropped on full queue
//   o_Underflow           sticky: pop on empty queue
//   o_Timeout             sticky: drain timed out
//   o_Done                level, checking finished
module float_result_checker #(
  parameter int pExpW         = 11,
  parameter int pManW         = 52,
  parameter int pDepth        = 16,
  parameter int pUlpTol       = 0,
  parameter int pDrainTimeout = 1024
) (
  input  logic                   i_Clk,
  input  logic                   i_ARst,
  input  logic                   i_ClkEn,
  input  logic                   i_EoF,
  input  logic [31:0]            iv_FltID,
  input  logic [pExpW+pManW:0]   iv_FltExp,
  input  logic                   i_ResValid,
  input  logic [pExpW+pManW:0]   iv_FltRes,
  output logic                   o_Mismatch,
  output logic [31:0]            ov_ErrID,
  output logic [31:0]            ov_PassCnt,
  output logic [31:0]            ov_ErrCnt,
  output logic                   o_Overflow,
  output logic                   o_Underflow,
  output logic                   o_Timeout,
  output logic                   o_Done
);

  localparam int W  = pExpW + pManW + 1;
  localparam int AW = $clog2(pDepth);
  localparam int CW = $clog2(pDrainTimeout) + 1;
  localparam logic [CW-1:0] DRAIN_LIM = CW'(pDrainTimeout - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t        r_state;
  state_t        w_next;

  logic [31:0]   r_id_mem  [pDepth];
  logic [W-1:0]  r_exp_mem [pDepth];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic [CW-1:0] r_drain_cnt;

  logic          r_mismatch;
  logic [31:0]   r_err_id;
  logic [31:0]   r_pass_cnt;
  logic [31:0]   r_err_cnt;
  logic          r_overflow;
  logic          r_underflow;
  logic          r_timeout;

  logic          w_done;
  logic          w_drain_expired;
  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_wr_en;
  logic          w_rd_en;
  logic          w_ovf;
  logic          w_udf;

  // Queue status is taken from the pointers before this cycle's push/pop.
  // The pointer MSB tells a full queue apart from an empty one when the
  // index bits are equal.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  assign w_push  = i_ClkEn & ~i_EoF & ~w_done;
  assign w_pop   = i_ResValid & ~w_done;

  // A push into a full queue still lands when the same cycle pops, because
  // the pop frees the head slot. A pop on an empty queue never consumes the
  // entry pushed in that same cycle.
  assign w_wr_en = w_push & (~w_full | w_pop);
  assign w_rd_en = w_pop & ~w_empty;
  assign w_ovf   = w_push & w_full & ~w_pop;
  assign w_udf   = w_pop & w_empty;

  always_ff @(posedge i_Clk) begin
    if (w_wr_en) begin
      r_id_mem[r_wr_ptr[AW-1:0]]  <= iv_FltID;
      r_exp_mem[r_wr_ptr[AW-1:0]] <= iv_FltExp;
    end
  end

  always_ff @(posedge i_Clk or posedge i_ARst) begin
    if (i_ARst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Compare of the queue head against the incoming DUT result
  logic [31:0]      w_head_id;
  logic [W-1:0]     w_head_exp;
  logic [pExpW-1:0] w_e_exp;
  logic [pExpW-1:0] w_r_exp;
  logic [pManW-1:0] w_e_man;
  logic [pManW-1:0] w_r_man;
  logic [W-1:0]     w_e_mag;
  logic [W-1:0]     w_r_mag;
  logic [W-1:0]     w_diff;
  logic             w_both_nan;
  logic             w_both_zero;
  logic             w_both_fin;
  logic             w_pass;

  assign w_head_id  = r_id_mem[r_rd_ptr[AW-1:0]];
  assign w_head_exp = r_exp_mem[r_rd_ptr[AW-1:0]];
  assign w_e_exp    = w_head_exp[W-2:pManW];
  assign w_r_exp    = iv_FltRes[W-2:pManW];
  assign w_e_man    = w_head_exp[pManW-1:0];
  assign w_r_man    = iv_FltRes[pManW-1:0];

  // Magnitudes are zero-extended to the full word width, so the absolute
  // difference below cannot wrap.
  assign w_e_mag    = {1'b0, w_head_exp[W-2:0]};
  assign w_r_mag    = {1'b0, iv_FltRes[W-2:0]};
  assign w_diff     = (w_r_mag >= w_e_mag) ? (w_r_mag - w_e_mag) : (w_e_mag - w_r_mag);

  assign w_both_nan  = (&w_e_exp) && (|w_e_man) && (&w_r_exp) && (|w_r_man);
  assign w_both_zero = (w_e_mag == '0) && (w_r_mag == '0);
  assign w_both_fin  = ~(&w_e_exp) && ~(&w_r_exp);

  // The equality term also covers an infinity matched against an infinity
  // of the same sign.
  assign w_pass = (w_head_exp == iv_FltRes) || w_both_nan || w_both_zero ||
                  ((w_head_exp[W-1] == iv_FltRes[W-1]) && w_both_fin &&
                   (w_diff <= W'(pUlpTol)));

  always_ff @(posedge i_Clk or posedge i_ARst) begin
    if (i_ARst) begin
      r_mismatch  <= 1'b0;
      r_err_id    <= '0;
      r_pass_cnt  <= '0;
      r_err_cnt   <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_mismatch <= 1'b0;
      if (w_rd_en && w_pass) begin
        if (r_pass_cnt != '1) r_pass_cnt <= r_pass_cnt + 32'd1;
      end else if (w_rd_en || w_udf) begin
        r_mismatch <= 1'b1;
        r_err_id   <= w_udf ? 32'hFFFF_FFFF : w_head_id;
        if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 32'd1;
      end
      if (w_ovf)           r_overflow  <= 1'b1;
      if (w_udf)           r_underflow <= 1'b1;
      if (w_drain_expired) r_timeout   <= 1'b1;
    end
  end

  // Drain watchdog: counts DRAIN cycles without a result and restarts on
  // every pop.
  always_ff @(posedge i_Clk or posedge i_ARst) begin
    if (i_ARst) begin
      r_drain_cnt <= '0;
    end else if (r_state != DRAIN || w_pop) begin
      r_drain_cnt <= '0;
    end else if (r_drain_cnt != DRAIN_LIM) begin
      r_drain_cnt <= r_drain_cnt + 1'b1;
    end
  end

  // FSM: state register
  always_ff @(posedge i_Clk or posedge i_ARst) begin
    if (i_ARst) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // FSM: next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (i_ClkEn && i_EoF) w_next = DRAIN;
        else if (w_push)      w_next = RUN;
      end
      RUN: begin
        if (i_ClkEn && i_EoF) w_next = DRAIN;
      end
      DRAIN: begin
        // Being empty with no pop this cycle means no compare is in
        // flight, so the last result is already on the outputs.
        if ((w_empty && !w_pop) || w_drain_expired) w_next = DONE;
      end
      DONE:    w_next = DONE;
      default: w_next = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    w_done          = 1'b0;
    w_drain_expired = 1'b0;
    case (r_state)
      DRAIN:   w_drain_expired = ~w_pop & ~w_empty & (r_drain_cnt == DRAIN_LIM);
      DONE:    w_done = 1'b1;
      default: w_done = 1'b0;
    endcase
  end

  assign o_Mismatch  = r_mismatch;
  assign ov_ErrID    = r_err_id;
  assign ov_PassCnt  = r_pass_cnt;
  assign ov_ErrCnt   = r_err_cnt;
  assign o_Overflow  = r_overflow;
  assign o_Underflow = r_underflow;
  assign o_Timeout   = r_timeout;
  assign o_Done      = w_done;

endmodule
